// File: rtl/clause_status_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : clause_status_accumulator
// Description : Folds a stream of sub-clause beats into one clause verdict
//               (SAT / UNIT / CONFLICT / UNRESOLVED) with the implied
//               assignment for UNIT. Valid/ready handshakes on both sides.
// Options     : CLAUSE_STATS_EN adds saturating CONFLICT/UNIT counters.
// Revision    : 1.0 - initial release
// ============================================================================
module clause_status_accumulator #(
    parameter int VAR_PER_CLAUSE = 5,
    parameter int VAR_ID_W       = 8,
    parameter int MAX_BEATS      = 4,
    parameter int BEAT_W         = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic                      in_partial_sat,
    input  logic [VAR_PER_CLAUSE-1:0] in_unassign,
    input  logic [VAR_PER_CLAUSE-1:0] in_mask,
    input  logic [VAR_PER_CLAUSE-1:0] in_pole,
    input  logic [VAR_ID_W-1:0]       in_var_base,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_status,
    output logic [VAR_ID_W-1:0]       out_unit_var,
    output logic                      out_unit_val,
    output logic [BEAT_W-1:0]         out_beats
`ifdef CLAUSE_STATS_EN
    ,
    output logic [15:0]               stat_conflicts,
    output logic [15:0]               stat_units
`endif
);

    localparam logic [1:0] ST_UNRESOLVED = 2'b00;
    localparam logic [1:0] ST_SAT        = 2'b01;
    localparam logic [1:0] ST_UNIT       = 2'b10;
    localparam logic [1:0] ST_CONFLICT   = 2'b11;

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic                      sat_q, sat_d;
    logic [1:0]                ucnt_q, ucnt_d;
    logic [VAR_ID_W-1:0]       uvar_q, uvar_d;
    logic                      uval_q, uval_d;
    logic [BEAT_W-1:0]         beats_q, beats_d;
    logic                      ovalid_q, ovalid_d;
    logic [1:0]                ostatus_q, ostatus_d;
    logic [VAR_ID_W-1:0]       ovar_q, ovar_d;
    logic                      oval_q, oval_d;
    logic [BEAT_W-1:0]         obeats_q, obeats_d;
    logic [15:0]               sconf_q, sconf_d;
    logic [15:0]               sunit_q, sunit_d;

    logic [VAR_PER_CLAUSE-1:0] w_u;
    logic [31:0]               w_sum;
    logic [1:0]                w_ucnt_new;
    logic                      w_sat_new;
    logic [VAR_ID_W-1:0]       w_low_var;
    logic                      w_low_val;
    logic [VAR_ID_W-1:0]       w_var_new;
    logic                      w_val_new;
    logic [BEAT_W-1:0]         w_beats_new;
    logic                      w_accept;
    logic                      w_final;
    logic [1:0]                w_verdict;

    // A freshly reset block stays not-ready for one cycle; flush always blocks beats.
    assign in_ready  = ready_q && !flush;
    assign w_accept  = in_valid && in_ready;

    // Beat fold: saturating unassigned count and lowest-lane unit candidate.
    always_comb begin
        w_u       = in_unassign & in_mask;
        w_sum     = 32'(ucnt_q);
        w_low_var = '0;
        w_low_val = 1'b0;
        // Scan high-to-low so the lowest set lane is the last one written.
        for (int i = VAR_PER_CLAUSE - 1; i >= 0; i--) begin
            if (w_u[i]) begin
                w_sum     = w_sum + 32'd1;
                w_low_var = in_var_base + VAR_ID_W'(i);
                w_low_val = ~in_pole[i];
            end
        end
        w_ucnt_new  = (w_sum >= 32'd2) ? 2'd2 : w_sum[1:0];
        w_sat_new   = sat_q | in_partial_sat;
        // Only the very first unassigned literal of the clause can be the unit.
        w_var_new   = ((ucnt_q == 2'd0) && (w_u != '0)) ? w_low_var : uvar_q;
        w_val_new   = ((ucnt_q == 2'd0) && (w_u != '0)) ? w_low_val : uval_q;
        w_beats_new = beats_q + BEAT_W'(1);
        w_final     = w_accept && (in_last || (w_beats_new == BEAT_W'(MAX_BEATS)));
        if (w_sat_new) begin
            w_verdict = ST_SAT;
        end else begin
            case (w_ucnt_new)
                2'd0:    w_verdict = ST_CONFLICT;
                2'd1:    w_verdict = ST_UNIT;
                default: w_verdict = ST_UNRESOLVED;
            endcase
        end
    end

    // Next-state logic: flush overrides accumulate, finalize and result handshake.
    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        sat_d     = sat_q;
        ucnt_d    = ucnt_q;
        uvar_d    = uvar_q;
        uval_d    = uval_q;
        beats_d   = beats_q;
        ovalid_d  = ovalid_q;
        ostatus_d = ostatus_q;
        ovar_d    = ovar_q;
        oval_d    = oval_q;
        obeats_d  = obeats_q;
        sconf_d   = sconf_q;
        sunit_d   = sunit_q;

        // Counters track completed handshakes only; a flushed result never counts.
        if (ovalid_q && out_ready && !flush) begin
            if ((ostatus_q == ST_CONFLICT) && (sconf_q != 16'hFFFF)) sconf_d = sconf_q + 16'd1;
            if ((ostatus_q == ST_UNIT) && (sunit_q != 16'hFFFF))     sunit_d = sunit_q + 16'd1;
        end

        if (flush) begin
            state_d  = S_ACCUM;
            ready_d  = 1'b1;
            sat_d    = 1'b0;
            ucnt_d   = 2'd0;
            uvar_d   = '0;
            uval_d   = 1'b0;
            beats_d  = '0;
            ovalid_d = 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    ready_d = 1'b1;
                    if (w_final) begin
                        state_d   = S_HOLD;
                        ready_d   = 1'b0;
                        ovalid_d  = 1'b1;
                        ostatus_d = w_verdict;
                        ovar_d    = (w_verdict == ST_UNIT) ? w_var_new : '0;
                        oval_d    = (w_verdict == ST_UNIT) ? w_val_new : 1'b0;
                        obeats_d  = w_beats_new;
                        sat_d     = 1'b0;
                        ucnt_d    = 2'd0;
                        uvar_d    = '0;
                        uval_d    = 1'b0;
                        beats_d   = '0;
                    end else if (w_accept) begin
                        sat_d   = w_sat_new;
                        ucnt_d  = w_ucnt_new;
                        uvar_d  = w_var_new;
                        uval_d  = w_val_new;
                        beats_d = w_beats_new;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d  = S_ACCUM;
                        ready_d  = 1'b1;
                        ovalid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_ACCUM;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_ACCUM;
            ready_q   <= 1'b0;
            sat_q     <= 1'b0;
            ucnt_q    <= 2'd0;
            uvar_q    <= '0;
            uval_q    <= 1'b0;
            beats_q   <= '0;
            ovalid_q  <= 1'b0;
            ostatus_q <= 2'b00;
            ovar_q    <= '0;
            oval_q    <= 1'b0;
            obeats_q  <= '0;
            sconf_q   <= 16'd0;
            sunit_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            sat_q     <= sat_d;
            ucnt_q    <= ucnt_d;
            uvar_q    <= uvar_d;
            uval_q    <= uval_d;
            beats_q   <= beats_d;
            ovalid_q  <= ovalid_d;
            ostatus_q <= ostatus_d;
            ovar_q    <= ovar_d;
            oval_q    <= oval_d;
            obeats_q  <= obeats_d;
            sconf_q   <= sconf_d;
            sunit_q   <= sunit_d;
        end
    end

    assign out_valid    = ovalid_q;
    assign out_status   = ostatus_q;
    assign out_unit_var = ovar_q;
    assign out_unit_val = oval_q;
    assign out_beats    = obeats_q;

`ifdef CLAUSE_STATS_EN
    assign stat_conflicts = sconf_q;
    assign stat_units     = sunit_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{sconf_q, sunit_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_clause_status_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_clause_status_accumulator
// Description : Directed and random stimulus for clause_status_accumulator,
//               compared every cycle against a clause-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clause_status_accumulator;

    localparam int LANES     = 5;
    localparam int MAX_BEATS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_last = 1'b0;
    logic       in_partial_sat = 1'b0;
    logic [4:0] in_unassign = '0;
    logic [4:0] in_mask = '0;
    logic [4:0] in_pole = '0;
    logic [7:0] in_var_base = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_status;
    logic [7:0] out_unit_var;
    logic       out_unit_val;
    logic [2:0] out_beats;
`ifdef CLAUSE_STATS_EN
    logic [15:0] stat_conflicts;
    logic [15:0] stat_units;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    clause_status_accumulator dut (
        .clock          (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_partial_sat (in_partial_sat),
        .in_unassign    (in_unassign),
        .in_mask        (in_mask),
        .in_pole        (in_pole),
        .in_var_base    (in_var_base),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_status     (out_status),
        .out_unit_var   (out_unit_var),
        .out_unit_val   (out_unit_val),
        .out_beats      (out_beats)
`ifdef CLAUSE_STATS_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_units     (stat_units)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (clause level) ----------------
    typedef struct {
        logic       sat;
        logic [4:0] u;
        logic [4:0] pole;
        logic [7:0] base;
    } beat_t;

    beat_t      q[$];
    logic       m_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic [1:0] m_status = '0;
    logic [7:0] m_var = '0;
    logic       m_val = 1'b0;
    logic [2:0] m_beats = '0;
    logic [15:0] m_sc = '0;
    logic [15:0] m_su = '0;

    // Verdict from the whole list of beats of a clause.
    task automatic finalize_clause();
        bit         anysat = 1'b0;
        int         nun = 0;
        logic [7:0] fvar = '0;
        logic       fval = 1'b0;
        foreach (q[b]) begin
            anysat |= q[b].sat;
            for (int i = 0; i < LANES; i++) begin
                if (q[b].u[i]) begin
                    if (nun == 0) begin
                        fvar = q[b].base + 8'(i);
                        fval = !q[b].pole[i];
                    end
                    nun++;
                end
            end
        end
        if (anysat)        m_status = 2'b01;
        else if (nun == 0) m_status = 2'b11;
        else if (nun == 1) m_status = 2'b10;
        else               m_status = 2'b00;
        m_var   = (m_status == 2'b10) ? fvar : 8'd0;
        m_val   = (m_status == 2'b10) ? fval : 1'b0;
        m_beats = 3'(q.size());
        m_valid = 1'b1;
        m_ready = 1'b0;
        q.delete();
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_valid = 1'b0; m_ready = 1'b0; m_status = '0;
            m_var = '0; m_val = 1'b0; m_beats = '0; m_sc = '0; m_su = '0;
        end else begin
            if (m_valid && out_ready && !flush) begin
                if (m_status == 2'b11 && m_sc != 16'hFFFF) m_sc++;
                if (m_status == 2'b10 && m_su != 16'hFFFF) m_su++;
            end
            if (flush) begin
                q.delete();
                m_valid = 1'b0;
                m_ready = 1'b1;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_ready = 1'b1;
                end
            end else if (!m_ready) begin
                m_ready = 1'b1;
            end else if (in_valid) begin
                q.push_back('{sat: in_partial_sat, u: in_unassign & in_mask,
                              pole: in_pole, base: in_var_base});
                if (in_last || q.size() == MAX_BEATS) finalize_clause();
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            chk("in_ready", in_ready, m_ready && !flush);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_status", out_status, m_status);
                chk("out_unit_var", out_unit_var, m_var);
                chk("out_unit_val", out_unit_val, m_val);
                chk("out_beats", out_beats, m_beats);
            end
`ifdef CLAUSE_STATS_EN
            chk("stat_conflicts", stat_conflicts, m_sc);
            chk("stat_units", stat_units, m_su);
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic sat, input logic [4:0] un, input logic [4:0] mask,
                        input logic [4:0] pole, input logic [7:0] base, input logic last);
        in_valid = 1'b1; in_partial_sat = sat; in_unassign = un; in_mask = mask;
        in_pole = pole; in_var_base = base; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        #2;
        chk("reset_valid", out_valid, 0);
        chk("reset_status", out_status, 0);
        chk("reset_beats", out_beats, 0);
        chk("reset_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clk); #2;
        chk("ready_after_reset", in_ready, 1);

        // single-beat SAT
        send(1, 5'b01111, 5'b11100, 5'b00000, 8'd0, 1); #2;
        chk("t1_valid", out_valid, 1);
        chk("t1_status", out_status, 2'b01);
        chk("t1_beats", out_beats, 1);
        chk("t1_var", out_unit_var, 0);
        chk("t1_val", out_unit_val, 0);
        consume(); #2;
        chk("t1_valid_after", out_valid, 0);
        chk("t1_ready_after", in_ready, 1);

        // single-beat UNIT
        send(0, 5'b00100, 5'b11111, 5'b00111, 8'd10, 1); #2;
        chk("t2_status", out_status, 2'b10);
        chk("t2_var", out_unit_var, 12);
        chk("t2_val", out_unit_val, 0);
        consume();

        // two beats, two unassigned -> UNRESOLVED
        send(0, 5'b00001, 5'b00001, 5'b00000, 8'd0, 0);
        send(0, 5'b00010, 5'b00010, 5'b00000, 8'd5, 1); #2;
        chk("t3_status", out_status, 2'b00);
        chk("t3_beats", out_beats, 2);
        consume();

        // two beats, one unassigned -> UNIT var 0
        send(0, 5'b00001, 5'b00001, 5'b00000, 8'd0, 0);
        send(0, 5'b00000, 5'b11111, 5'b00000, 8'd5, 1); #2;
        chk("t3b_status", out_status, 2'b10);
        chk("t3b_var", out_unit_var, 0);
        chk("t3b_val", out_unit_val, 1);
        chk("t3b_beats", out_beats, 2);
        consume();

        // four beats without last -> CONFLICT
        for (int b = 0; b < 4; b++) send(0, 5'b00000, 5'b11111, 5'b10101, 8'(b * 5), 0);
        #2;
        chk("t4_valid", out_valid, 1);
        chk("t4_status", out_status, 2'b11);
        chk("t4_beats", out_beats, 4);
        chk("t4_ready", in_ready, 0);

        // held result then flush on the third stalled cycle
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #2;
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_status", out_status, 2'b11);
            chk("t5_hold_ready", in_ready, 0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_flush_ready", in_ready, 1);

`ifdef CLAUSE_STATS_EN
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            send(0, 5'b00000, 5'b00000, 5'b00000, 8'd0, 1);
            consume();
        end
        send(0, 5'b00001, 5'b00001, 5'b00000, 8'd3, 1);
        consume(); #2;
        chk("st_conf", stat_conflicts, 3);
        chk("st_unit", stat_units, 1);
        flush = 1'b1; @(negedge clk); flush = 1'b0; #2;
        chk("st_conf_flush", stat_conflicts, 3);
        chk("st_unit_flush", stat_units, 1);
        reset = 1'b1; @(negedge clk); reset = 1'b0; #2;
        chk("st_conf_reset", stat_conflicts, 0);
        chk("st_unit_reset", stat_units, 0);
`endif

        // random phase
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            reset          = ($urandom_range(0, 199) == 0);
            flush          = ($urandom_range(0, 29) == 0);
            in_valid       = ($urandom_range(0, 9) < 7);
            in_last        = ($urandom_range(0, 2) == 0);
            in_partial_sat = ($urandom_range(0, 3) == 0);
            in_unassign    = 5'($urandom) & 5'($urandom);
            in_mask        = 5'($urandom);
            in_pole        = 5'($urandom);
            in_var_base    = 8'($urandom);
            out_ready      = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
